nibble_swap_arbiter: RTL and testbench

NIBBLE_SWAP_ARBITER -- requirements
Module: nibble_swap_arbiter

---
 rtl/nibble_swap_arbiter_if.sv | 38 +++
 rtl/nibble_swap_arbiter.sv | 105 ++++++++++
 tb/tb_nibble_swap_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_swap_arbiter_if.sv
// Handshake bundle between two byte requesters, the nibble-swap arbiter and its downstream consumer.
interface nibble_swap_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic [1:0]       cfg_mode;
    logic             a_valid;
    logic             a_swap;
    logic [7:0]       a_data;
    logic             a_ready;
    logic             b_valid;
    logic             b_swap;
    logic [7:0]       b_data;
    logic             b_ready;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_src;
    logic [CNT_W-1:0] xfer_cnt;

    modport slave (
        input  en, cfg_mode,
        input  a_valid, a_swap, a_data,
        input  b_valid, b_swap, b_data,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_data, out_src, xfer_cnt
    );

    modport master (
        output en, cfg_mode,
        output a_valid, a_swap, a_data,
        output b_valid, b_swap, b_data,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_data, out_src, xfer_cnt
    );
endinterface

// File: rtl/nibble_swap_arbiter.sv
// Round-robin arbiter between two byte requesters with an optional nibble swap,
// a single-entry registered output stage and a completed-transfer counter.
module nibble_swap_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_swap_arbiter_if.slave bus
);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             src_q, src_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       can_accept;
    logic       a_gnt;
    logic       b_gnt;
    logic       gnt_swap;
    logic       swap_eff;
    logic [7:0] gnt_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= 8'h00;
            src_q   <= SRC_A;
            last_q  <= SRC_B;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant decision, swap policy and next-state for the output stage.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        src_d      = src_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        can_accept = 1'b0;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        gnt_swap   = 1'b0;
        swap_eff   = 1'b0;
        gnt_data   = 8'h00;

        // rst_n gates the readies so nothing is offered while reset is held.
        can_accept = rst_n && bus.en && ((state_q == EMPTY) || bus.out_ready);
        a_gnt = can_accept && bus.a_valid && (!bus.b_valid || (last_q == SRC_B));
        b_gnt = can_accept && bus.b_valid && (!bus.a_valid || (last_q == SRC_A));

        gnt_data = b_gnt ? bus.b_data : bus.a_data;
        gnt_swap = b_gnt ? bus.b_swap : bus.a_swap;

        case (bus.cfg_mode)
            2'b01:   swap_eff = 1'b0;
            2'b10:   swap_eff = 1'b1;
            default: swap_eff = gnt_swap;
        endcase

        if ((state_q == FULL) && bus.out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            EMPTY: begin
                if (a_gnt || b_gnt) state_d = FULL;
            end
            FULL: begin
                if (a_gnt || b_gnt)     state_d = FULL;
                else if (bus.out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (a_gnt || b_gnt) begin
            data_d = swap_eff ? {gnt_data[3:0], gnt_data[7:4]} : gnt_data;
            src_d  = b_gnt ? SRC_B : SRC_A;
            last_d = b_gnt ? SRC_B : SRC_A;
        end
    end

    assign bus.a_ready   = a_gnt;
    assign bus.b_ready   = b_gnt;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_nibble_swap_arbiter.sv
// Directed bench for nibble_swap_arbiter: reset, arbitration, swap modes, stall, enable and counter wrap.
module tb_nibble_swap_arbiter;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    nibble_swap_arbiter_if #(.CNT_W(CNT_W)) bus ();

    nibble_swap_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid  = 1'b0;
        bus.a_swap   = 1'b0;
        bus.a_data   = 8'h00;
        bus.b_valid  = 1'b0;
        bus.b_swap   = 1'b0;
        bus.b_data   = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        bus.en        = 1'b1;
        bus.cfg_mode  = 2'b00;
        bus.out_ready = 1'b1;
        bus.a_valid   = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_out_src",   32'(bus.out_src),   32'h0);
        chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'h0);
        chk("rst_a_ready",   32'(bus.a_ready),   32'h0);
        tick();
        rst_n = 1'b1;

        // Single requester A with per-request swap.
        bus.a_data = 8'hA5;
        bus.a_swap = 1'b1;
        #1;
        chk("t1_a_ready", 32'(bus.a_ready), 32'h1);
        chk("t1_b_ready", 32'(bus.b_ready), 32'h0);
        tick();
        idle_inputs();
        chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
        chk("t1_out_data",  32'(bus.out_data),  32'hA5 >> 4 | 32'h50);
        chk("t1_out_src",   32'(bus.out_src),   32'h0);
        chk("t1_cnt0",      32'(bus.xfer_cnt),  32'h0);
        tick();
        chk("t1_cnt1",      32'(bus.xfer_cnt),  32'h1);
        chk("t1_drained",   32'(bus.out_valid), 32'h0);

        // Round-robin with both requesters valid.
        do_reset();
        bus.a_valid = 1'b1; bus.a_data = 8'h11;
        bus.b_valid = 1'b1; bus.b_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", 32'(bus.a_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_b_ready", 32'(bus.b_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            chk("rr_out_src",  32'(bus.out_src),  (i % 2 == 0) ? 32'h0 : 32'h1);
            chk("rr_out_data", 32'(bus.out_data), (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        chk("rr_cnt", 32'(bus.xfer_cnt), 32'h3);

        // Stall for three cycles with both valid, then drain plus regrant.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_a_ready", 32'(bus.a_ready), 32'h0);
            chk("stall_b_ready", 32'(bus.b_ready), 32'h0);
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'h1);
            chk("stall_data",  32'(bus.out_data),  32'h22);
            chk("stall_src",   32'(bus.out_src),   32'h1);
        end
        chk("stall_cnt", 32'(bus.xfer_cnt), 32'h3);
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_a_ready", 32'(bus.a_ready), 32'h1);
        tick();
        chk("unstall_src",  32'(bus.out_src),  32'h0);
        chk("unstall_data", 32'(bus.out_data), 32'h11);
        chk("unstall_cnt",  32'(bus.xfer_cnt), 32'h4);
        idle_inputs();
        tick();
        chk("empty_valid", 32'(bus.out_valid), 32'h0);
        chk("empty_cnt",   32'(bus.xfer_cnt),  32'h5);

        // Forced swap on B, forced pass-through on A, reserved mode acts per-request.
        bus.cfg_mode = 2'b10;
        bus.b_valid = 1'b1; bus.b_data = 8'h3C; bus.b_swap = 1'b0;
        tick();
        chk("m10_data", 32'(bus.out_data), 32'hC3);
        chk("m10_src",  32'(bus.out_src),  32'h1);
        idle_inputs();
        bus.cfg_mode = 2'b01;
        bus.a_valid = 1'b1; bus.a_data = 8'h12; bus.a_swap = 1'b1;
        tick();
        chk("m01_data", 32'(bus.out_data), 32'h12);
        chk("m01_src",  32'(bus.out_src),  32'h0);
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.cfg_mode  = 2'b10;
        tick();
        chk("held_data", 32'(bus.out_data), 32'h12);
        bus.out_ready = 1'b1;
        bus.cfg_mode  = 2'b11;
        bus.a_valid = 1'b1; bus.a_data = 8'hF0; bus.a_swap = 1'b1;
        tick();
        chk("m11_data", 32'(bus.out_data), 32'h0F);

        // Enable low blocks grants while the held result still drains.
        bus.en = 1'b0;
        #1;
        chk("en0_a_ready", 32'(bus.a_ready), 32'h0);
        tick();
        chk("en0_drain", 32'(bus.out_valid), 32'h0);
        tick();
        chk("en0_stay_empty", 32'(bus.out_valid), 32'h0);
        bus.en = 1'b1;
        idle_inputs();

        // Counter wrap with CNT_W=4, then async reset while FULL.
        do_reset();
        bus.a_valid = 1'b1; bus.a_data = 8'h77;
        for (int i = 0; i < 16; i++) tick();
        chk("wrap_cnt15", 32'(bus.xfer_cnt), 32'hF);
        tick();
        chk("wrap_cnt0",  32'(bus.xfer_cnt), 32'h0);
        chk("wrap_full",  32'(bus.out_valid), 32'h1);
        tick();
        chk("wrap_cnt1",  32'(bus.xfer_cnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'h0);
        chk("async_cnt",   32'(bus.xfer_cnt),  32'h0);
        chk("async_ready", 32'(bus.a_ready),   32'h0);
        rst_n = 1'b1;
        bus.b_valid = 1'b1; bus.b_data = 8'h44;
        #1;
        chk("post_tie_a", 32'(bus.a_ready), 32'h1);
        chk("post_tie_b", 32'(bus.b_ready), 32'h0);
        tick();
        chk("post_src",  32'(bus.out_src),  32'h0);
        chk("post_data", 32'(bus.out_data), 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
